// File: rtl/pipe_ctrl.sv
// Pipeline stall controller and EX-stage multi-cycle sequencer (madd/msub, divide).
// Merges ID/MEM stall requests with EX sequencing into the stop vector and drives the divider handshake.
module pipe_ctrl #(
    parameter int DIV_MAX_CYCLES = 40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stallreq_id,
    input  logic       stallreq_mem,
    input  logic       ex_madd_i,
    input  logic       ex_div_i,
    input  logic       div_ready_i,
    input  logic       flush_i,
    output logic [5:0] stop,
    output logic       div_start_o,
    output logic       div_annul_o,
    output logic       div_timeout_o,
    output logic       ex_busy_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MADD2    = 2'd1,
        DIV_WAIT = 2'd2
    } state_t;

    localparam logic [5:0] DCNT_LAST = 6'(DIV_MAX_CYCLES - 1);

    localparam logic [5:0] STOP_NONE = 6'b000000;
    localparam logic [5:0] STOP_ID   = 6'b000111;
    localparam logic [5:0] STOP_EX   = 6'b001111;
    localparam logic [5:0] STOP_MEM  = 6'b011111;

    state_t     state, state_nxt;
    logic [5:0] dcnt, dcnt_nxt;
    logic       hold;
    logic       timeout_hit;
    logic       ex_stall;

    assign hold = stallreq_mem & ~flush_i;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            dcnt          <= '0;
            div_timeout_o <= 1'b0;
        end else begin
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
            if (timeout_hit)
                div_timeout_o <= 1'b1;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        dcnt_nxt    = dcnt;
        timeout_hit = 1'b0;
        if (flush_i) begin
            state_nxt = IDLE;
            dcnt_nxt  = '0;
        end else if (!hold) begin
            unique case (state)
                IDLE: begin
                    // madd wins if both are flagged; that combination is illegal anyway
                    if (ex_madd_i) begin
                        state_nxt = MADD2;
                    end else if (ex_div_i) begin
                        state_nxt = DIV_WAIT;
                        dcnt_nxt  = '0;
                    end
                end
                MADD2: state_nxt = IDLE;
                DIV_WAIT: begin
                    if (div_ready_i) begin
                        state_nxt = IDLE;
                    end else if (dcnt == DCNT_LAST) begin
                        state_nxt   = IDLE;
                        timeout_hit = 1'b1;
                    end else begin
                        dcnt_nxt = dcnt + 6'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        ex_stall    = 1'b0;
        stop        = STOP_NONE;
        div_start_o = 1'b0;
        div_annul_o = 1'b0;
        ex_busy_o   = 1'b0;
        unique case (state)
            IDLE:     ex_stall = ex_madd_i | ex_div_i;
            MADD2:    ex_stall = 1'b0;
            DIV_WAIT: ex_stall = ~div_ready_i;
            default:  ex_stall = 1'b0;
        endcase
        if (rst_n) begin
            if (flush_i)           stop = STOP_NONE;
            else if (stallreq_mem) stop = STOP_MEM;
            else if (ex_stall)     stop = STOP_EX;
            else if (stallreq_id)  stop = STOP_ID;
            // a ready level seen in IDLE is stale, so start is gated only by the EX opcode
            div_start_o = (state == IDLE) & ex_div_i & ~ex_madd_i & ~hold & ~flush_i;
            div_annul_o = ((state == DIV_WAIT) & flush_i) | timeout_hit;
            ex_busy_o   = (state != IDLE);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pipe_ctrl;

    localparam int MAXC = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stallreq_id = 1'b0;
    logic       stallreq_mem = 1'b0;
    logic       ex_madd_i = 1'b0;
    logic       ex_div_i = 1'b0;
    logic       div_ready_i = 1'b0;
    logic       flush_i = 1'b0;
    logic [5:0] stop;
    logic       div_start_o, div_annul_o, div_timeout_o, ex_busy_o;

    int n_checks = 0;
    int n_errors = 0;

    pipe_ctrl #(.DIV_MAX_CYCLES(MAXC)) dut (
        .clk(clk), .rst_n(rst_n), .stallreq_id(stallreq_id), .stallreq_mem(stallreq_mem),
        .ex_madd_i(ex_madd_i), .ex_div_i(ex_div_i), .div_ready_i(div_ready_i), .flush_i(flush_i),
        .stop(stop), .div_start_o(div_start_o), .div_annul_o(div_annul_o),
        .div_timeout_o(div_timeout_o), .ex_busy_o(ex_busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks "what is the EX instruction doing": second madd cycle pending, or a divide in
    // progress together with how many wait cycles it has consumed.
    bit m_madd_second = 0;
    bit m_div_on      = 0;
    int m_waited      = 0;
    bit m_timeout     = 0;

    function automatic logic [5:0] exp_stop();
        bit ex_stall;
        if (!rst_n) return 6'b000000;
        if (m_div_on)           ex_stall = !div_ready_i;
        else if (m_madd_second) ex_stall = 0;
        else                    ex_stall = ex_madd_i | ex_div_i;
        if (flush_i)      return 6'b000000;
        if (stallreq_mem) return 6'b011111;
        if (ex_stall)     return 6'b001111;
        if (stallreq_id)  return 6'b000111;
        return 6'b000000;
    endfunction

    function automatic bit exp_start();
        return rst_n && !m_madd_second && !m_div_on && ex_div_i && !ex_madd_i
               && !stallreq_mem && !flush_i;
    endfunction

    function automatic bit exp_annul();
        if (!rst_n || !m_div_on) return 0;
        if (flush_i) return 1;
        return !stallreq_mem && !div_ready_i && (m_waited == MAXC - 1);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_madd_second = 0; m_div_on = 0; m_waited = 0; m_timeout = 0;
        end else if (flush_i) begin
            m_madd_second = 0; m_div_on = 0; m_waited = 0;
        end else if (stallreq_mem) begin
            // frozen
        end else if (m_madd_second) begin
            m_madd_second = 0;
        end else if (m_div_on) begin
            if (div_ready_i) begin
                m_div_on = 0;
            end else if (m_waited == MAXC - 1) begin
                m_div_on = 0; m_timeout = 1;
            end else begin
                m_waited++;
            end
        end else if (ex_madd_i) begin
            m_madd_second = 1;
        end else if (ex_div_i) begin
            m_div_on = 1; m_waited = 0;
        end
    end

    always @(negedge clk) begin
        check("stop",    32'(stop),          32'(exp_stop()));
        check("start",   32'(div_start_o),   32'(exp_start()));
        check("annul",   32'(div_annul_o),   32'(exp_annul()));
        check("busy",    32'(ex_busy_o),     32'(rst_n && (m_madd_second || m_div_on)));
        check("timeout", 32'(div_timeout_o), 32'(m_timeout));
    end

    // ---------------- stimulus helpers ----------------
    task automatic sample(); @(negedge clk); #1; endtask
    task automatic advance(); @(posedge clk); #1; endtask

    task automatic idle_inputs();
        stallreq_id = 0; stallreq_mem = 0; ex_madd_i = 0; ex_div_i = 0;
        div_ready_i = 0; flush_i = 0;
    endtask

    int  dv_cnt = 0;
    bit  s_seen, a_seen, r_seen;

    initial begin
        // reset
        idle_inputs();
        rst_n = 0;
        sample();
        check("rst_stop", 32'(stop), 32'h0);
        check("rst_busy", 32'(ex_busy_o), 32'h0);
        check("rst_tmo",  32'(div_timeout_o), 32'h0);
        advance(); rst_n = 1;

        // ID stall only
        stallreq_id = 1;
        sample(); check("id_c0", 32'(stop), 32'h07);
        advance();
        sample(); check("id_c1", 32'(stop), 32'h07); check("id_busy", 32'(ex_busy_o), 32'h0);
        advance(); stallreq_id = 0;
        sample(); check("id_c2", 32'(stop), 32'h00);
        advance();

        // madd, two cycles
        ex_madd_i = 1;
        sample(); check("madd_c1", 32'(stop), 32'h0f); check("madd_c1_busy", 32'(ex_busy_o), 32'h0);
        advance();
        sample(); check("madd_c2", 32'(stop), 32'h00); check("madd_c2_busy", 32'(ex_busy_o), 32'h1);
        advance(); ex_madd_i = 0;
        sample(); check("madd_done_busy", 32'(ex_busy_o), 32'h0);
        advance();

        // madd with MEM stall in the second cycle
        ex_madd_i = 1;
        sample(); check("maddm_c1", 32'(stop), 32'h0f);
        advance(); stallreq_mem = 1;
        sample(); check("maddm_c2", 32'(stop), 32'h1f);
        advance();
        sample(); check("maddm_c3", 32'(stop), 32'h1f); check("maddm_busy", 32'(ex_busy_o), 32'h1);
        advance(); stallreq_mem = 0;
        sample(); check("maddm_rel", 32'(stop), 32'h00);
        advance(); ex_madd_i = 0;
        sample(); check("maddm_idle", 32'(ex_busy_o), 32'h0);
        advance();

        // divide, ready rises 5 cycles after start
        ex_div_i = 1;
        sample(); check("div_c0_start", 32'(div_start_o), 32'h1); check("div_c0", 32'(stop), 32'h0f);
        for (int c = 1; c <= 4; c++) begin
            advance();
            sample();
            check("div_wait_stop", 32'(stop), 32'h0f);
            check("div_wait_start", 32'(div_start_o), 32'h0);
        end
        advance(); div_ready_i = 1;
        sample(); check("div_c5", 32'(stop), 32'h00);
        advance(); ex_div_i = 0;
        sample(); check("div_idle", 32'(ex_busy_o), 32'h0);
        advance();

        // flush at cycle 3 of DIV_WAIT together with MEM stall
        ex_div_i = 1; div_ready_i = 0;
        sample(); check("fl_start", 32'(div_start_o), 32'h1);
        advance(); ex_div_i = 0;
        advance(); advance();
        flush_i = 1; stallreq_mem = 1;
        sample(); check("fl_stop", 32'(stop), 32'h00); check("fl_annul", 32'(div_annul_o), 32'h1);
        advance(); flush_i = 0; stallreq_mem = 0;
        sample(); check("fl_busy", 32'(ex_busy_o), 32'h0); check("fl_tmo", 32'(div_timeout_o), 32'h0);
        advance();

        // synchronous reset during DIV_WAIT
        ex_div_i = 1;
        advance(); ex_div_i = 0;
        sample(); check("rd_busy_pre", 32'(ex_busy_o), 32'h1);
        advance(); rst_n = 0;
        sample();
        check("rd_stop", 32'(stop), 32'h0);
        check("rd_annul", 32'(div_annul_o), 32'h0);
        check("rd_busy", 32'(ex_busy_o), 32'h0);
        advance(); rst_n = 1;
        sample(); check("rd_post_busy", 32'(ex_busy_o), 32'h0); check("rd_post_tmo", 32'(div_timeout_o), 32'h0);
        advance();

        // divide timeout
        ex_div_i = 1;
        sample(); check("to_start", 32'(div_start_o), 32'h1);
        advance(); ex_div_i = 0;
        for (int c = 1; c < MAXC; c++) advance();
        // now in cycle MAXC-1... adjust: loop above left us at cycle MAXC
        sample(); check("to_annul", 32'(div_annul_o), 32'h1);
        advance();
        sample(); check("to_flag", 32'(div_timeout_o), 32'h1); check("to_busy", 32'(ex_busy_o), 32'h0);
        advance();
        sample(); check("to_sticky", 32'(div_timeout_o), 32'h1);
        advance();

        // randomized traffic with a divider model answering start/annul
        for (int n = 0; n < 4000; n++) begin
            rst_n        = ($urandom_range(0, 199) != 0);
            flush_i      = ($urandom_range(0, 39) == 0);
            stallreq_mem = ($urandom_range(0, 6) == 0);
            stallreq_id  = ($urandom_range(0, 4) == 0);
            ex_madd_i    = ($urandom_range(0, 6) == 0);
            ex_div_i     = ($urandom_range(0, 5) == 0);
            sample();
            s_seen = div_start_o; a_seen = div_annul_o; r_seen = rst_n;
            advance();
            if (!r_seen) begin
                div_ready_i = 0; dv_cnt = 0;
            end else if (s_seen) begin
                int lat = $urandom_range(1, 48);
                if (lat == 1) begin div_ready_i = 1; dv_cnt = 0; end
                else          begin div_ready_i = 0; dv_cnt = lat - 1; end
            end else if (a_seen) begin
                div_ready_i = 0; dv_cnt = 0;
            end else if (dv_cnt > 0) begin
                dv_cnt--;
                if (dv_cnt == 0) div_ready_i = 1;
            end
        end

        idle_inputs();
        sample();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
